// File: rtl/wb_arbiter_pkg.sv
// Shared CPU-side types for the write-back path: register/data widths,
// the buffered write request record and a one-hot helper for hazard masks.
package wb_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency units (master side) and the
// write-back arbiter (slave side), including the register-file write port.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                a_valid;
  logic [REG_AW-1:0]   a_rd;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid;
  logic                b_ready;
  logic [REG_AW-1:0]   b_rd;
  logic [DATA_W-1:0]   b_data;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] pend_mask;
  logic                stall_req;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  b_ready, rf_we, rf_waddr, rf_wdata, pend_mask, stall_req
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output b_ready, rf_we, rf_waddr, rf_wdata, pend_mask, stall_req
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Circular buffer for long-latency write-back results. Exposes per-slot
// valid and destination register so the arbiter can build the pending mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entry_valid = vld;

  // Pointers, occupancy and per-slot valid bits; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: slots are only read while their valid bit is set
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  // Flatten slot destinations for the pending-write mask
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port. The pipeline
// (port A) always wins; buffered long-latency results (port B) fill idle
// slots. A starvation counter raises stall_req so the FIFO eventually drains.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t                      push_req;
  wb_req_t                      head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_rd;
  logic                         a_win;
  logic                         b_ready_int;
  logic [SW-1:0]                starve_cnt;

  // A write to r0 is a no-op, so such a cycle is a free slot for the FIFO
  assign a_win       = bus.a_valid && (bus.a_rd != '0) && !reset;
  assign fifo_pop    = !a_win && !fifo_empty && !reset;
  assign b_ready_int = !fifo_full && !reset;
  assign fifo_push   = bus.b_valid && b_ready_int && (bus.b_rd != '0);
  assign push_req    = '{rd: bus.b_rd, data: bus.b_data};
  assign bus.b_ready = b_ready_int;
  assign bus.stall_req = (starve_cnt == SW'(STARVE_MAX));

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_req    (push_req),
    .pop         (fifo_pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Port A has zero-latency priority; otherwise the FIFO head uses the slot
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (a_win) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.a_rd;
      bus.rf_wdata = bus.a_data;
    end else if (fifo_pop) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head.rd;
      bus.rf_wdata = head.data;
    end
  end

  // Pending mask covers every buffered entry, including the head being written now
  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        bus.pend_mask = bus.pend_mask | rd_onehot(entry_rd[i]);
      end
    end
  end

  // Count consecutive cycles the FIFO loses to port A, saturating at the stall threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (a_win && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all scored against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_wr_t;

  logic clk;
  logic reset;
  wb_arbiter_if bus();

  wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_wr_t exp_q[$];
  wb_req_t model_q[$];
  int      model_starve;
  int      cyc;
  int      checks;
  int      errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the FIFO is a plain queue, the starvation rule is applied directly.
  task automatic checkOutput(input logic rst, input logic av, input logic [4:0] ard,
                             input logic [31:0] adata, input logic bv, input logic [4:0] brd,
                             input logic [31:0] bdata, output logic accepted);
    logic [31:0] mask;
    logic        room;
    logic        awin;
    logic        deq;
    logic        was_empty;
    accepted = 1'b0;
    if (rst) begin
      checkVal("b_ready_in_reset", 32'(bus.b_ready), 32'd0);
      model_q.delete();
      model_starve = 0;
      return;
    end
    room = (model_q.size() < DEPTH);
    mask = '0;
    foreach (model_q[i]) mask[model_q[i].rd] = 1'b1;
    checkVal("b_ready", 32'(bus.b_ready), 32'(room));
    checkVal("pend_mask", bus.pend_mask, mask);
    checkVal("stall_req", 32'(bus.stall_req), 32'(model_starve == STARVE_MAX));
    awin = av && (ard != 5'd0);
    deq = 1'b0;
    was_empty = (model_q.size() == 0);
    if (awin) begin
      exp_q.push_back('{cyc: cyc, rd: ard, data: adata});
    end else if (!was_empty) begin
      exp_q.push_back('{cyc: cyc, rd: model_q[0].rd, data: model_q[0].data});
      deq = 1'b1;
      void'(model_q.pop_front());
    end
    accepted = bv && room;
    if (accepted && (brd != 5'd0)) model_q.push_back('{rd: brd, data: bdata});
    if (was_empty || deq) model_starve = 0;
    else if (awin && model_starve < STARVE_MAX) model_starve++;
  endtask

  task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ard,
                               input logic [31:0] adata, input logic bv, input logic [4:0] brd,
                               input logic [31:0] bdata, output logic accepted);
    @(posedge clk);
    #1;
    cyc++;
    reset       = rst;
    bus.a_valid = av;
    bus.a_rd    = ard;
    bus.a_data  = adata;
    bus.b_valid = bv;
    bus.b_rd    = brd;
    bus.b_data  = bdata;
    #1;
    checkOutput(rst, av, ard, adata, bv, brd, bdata, accepted);
  endtask

  // Monitor: every cycle, compare the register-file port with the scoreboard head
  initial begin
    exp_wr_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        checks++;
        if (bus.rf_we === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            errors++;
            $display("[TB] FAIL unexpected_write cycle %0d: got r%0d=0x%0h expected no write",
                     cyc, bus.rf_waddr, bus.rf_wdata);
          end else begin
            e = exp_q.pop_front();
            if (bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data) begin
              errors++;
              $display("[TB] FAIL write_data cycle %0d: got r%0d=0x%0h expected r%0d=0x%0h",
                       cyc, bus.rf_waddr, bus.rf_wdata, e.rd, e.data);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          errors++;
          $display("[TB] FAIL missing_write cycle %0d: got rf_we=%b expected r%0d=0x%0h",
                   cyc, bus.rf_we, e.rd, e.data);
        end else if (bus.rf_we !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rf_we_idle cycle %0d: got %b expected 0", cyc, bus.rf_we);
        end
      end
    end
  end

  initial begin
    logic        acc;
    logic        pend_v;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    int          a_pct;
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_starve = 0;
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;

    // Reset, then idle: empty FIFO, no write, b_ready high
    applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // Port A only
    applyStimulus(0, 1, 5, 32'h1234, 0, 0, 0, acc);

    // Port B into an idle port
    applyStimulus(0, 0, 0, 0, 1, 7, 32'hDEAD, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // Fill the FIFO while A is busy, hold a fifth request, then drain
    pend_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 5'(i + 1), 32'hA000 + i, 1, 5'(10 + i), 32'hB000 + i, acc);
      if (!acc) pend_v = 1'b1;
    end
    applyStimulus(0, 1, 5'd6, 32'hA005, pend_v, 5'd14, 32'hB004, acc);
    if (acc) pend_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, pend_v, 5'd14, 32'hB004, acc);
      if (acc) pend_v = 1'b0;
    end

    // Starvation: one buffered entry loses to A until stall_req rises, then drains
    applyStimulus(0, 1, 5'd20, 32'hC0, 1, 5'd9, 32'h9999, acc);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 5'(i), 32'hC000 + i, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // Saturation: A keeps winning while stall_req is high
    applyStimulus(0, 1, 5'd21, 32'hD0, 1, 5'd11, 32'h1111, acc);
    for (int i = 1; i <= 11; i++) applyStimulus(0, 1, 5'(i), 32'hD000 + i, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // rd=0 cases: A to r0 frees the slot; B to r0 is accepted but dropped
    applyStimulus(0, 1, 5'd4, 32'hE0, 1, 5'd3, 32'h3333, acc);
    applyStimulus(0, 1, 5'd0, 32'hE1, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h0BAD, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // Reset with three buffered entries discards them
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 5'd2, 32'hF0 + i, 1, 5'(16 + i), 32'hF00 + i, acc);
    applyStimulus(1, 1, 5'd2, 32'hFF, 0, 0, 0, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    // Random traffic in bursts of varying port-A load
    pend_v = 1'b0; pend_rd = '0; pend_data = '0; a_pct = 70;
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) a_pct = (n % 150 == 0) ? 96 : ((n % 100 == 0) ? 30 : 70);
      if (!pend_v && $urandom_range(0, 99) < 45) begin
        pend_v    = 1'b1;
        pend_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pend_data = $urandom;
      end
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < a_pct),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom, pend_v, pend_rd, pend_data, acc);
      if (acc || reset) pend_v = 1'b0;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);

    @(negedge clk);
    #1;
    checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
